// File: rtl/mem_resp_pkg.sv
// Shared types and address-field width helpers for the data-memory responder.
package mem_resp_pkg;

    typedef enum logic {IDLE, MISS} mem_resp_state_t;

    function automatic int unsigned idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned set_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Tag is whatever remains of the word index above the set and offset fields
    function automatic int unsigned tag_w(input int unsigned depth,
                                          input int unsigned line_words,
                                          input int unsigned lines);
        return $clog2(depth) - $clog2(line_words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/miss_tag_array.sv
// Direct-mapped valid/tag table: combinational lookup, single fill-write port.
module miss_tag_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned SET_W = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SET_W-1:0] lookup_set,
    output logic             lookup_valid,
    output logic [TAG_W-1:0] lookup_tag,
    input  logic             fill_en,
    input  logic [SET_W-1:0] fill_set,
    input  logic [TAG_W-1:0] fill_tag
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < int'(LINES); i++) begin
                tag[i] <= '0;
            end
        end else if (fill_en) begin
            valid[fill_set] <= 1'b1;
            tag[fill_set]   <= fill_tag;
        end
    end

    assign lookup_valid = valid[lookup_set];
    assign lookup_tag   = tag[lookup_set];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory port responder: on-chip word store, segfault decode and a
// direct-mapped miss model with one fixed-latency fill outstanding at a time.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 16,
    parameter int unsigned MISS_LAT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wr_data,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [2:0]  d_trd,
    output logic [31:0] d_rd_data,
    output logic        d_miss,
    output logic        d_segfault,
    output logic        busy,
    output logic [2:0]  miss_trd,
    output logic [15:0] miss_count
);

    localparam int unsigned IDX_W = idx_w(DEPTH);
    localparam int unsigned OFF_W = off_w(LINE_WORDS);
    localparam int unsigned SET_W = set_w(LINES);
    localparam int unsigned TAG_W = tag_w(DEPTH, LINE_WORDS, LINES);
    localparam int unsigned CNT_W = $clog2(MISS_LAT + 1);

    mem_resp_state_t  state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       trd_next;
    logic [15:0]      count_next;
    logic [SET_W-1:0] fill_set, fill_set_next;
    logic [TAG_W-1:0] fill_tag, fill_tag_next;
    logic             fill_en;

    logic [31:0]      word;
    logic [IDX_W-1:0] idx;
    logic [SET_W-1:0] set;
    logic [TAG_W-1:0] tag;
    logic             req, bad, legal, hit, wr_en;
    logic             lk_valid;
    logic [TAG_W-1:0] lk_tag;
    logic [31:0]      mem [DEPTH];

    // Address decode; word/idx are only meaningful when the request is legal
    assign word = 32'((d_addr - BASE_ADDR) >> 2);
    assign idx  = word[IDX_W-1:0];
    assign set  = idx[OFF_W +: SET_W];
    assign tag  = idx[IDX_W-1 -: TAG_W];

    assign req   = d_rd | d_wr;
    assign bad   = (d_addr[1:0] != 2'b00) || (d_addr < BASE_ADDR)
                || (word >= 32'(DEPTH)) || (d_rd && d_wr);
    assign legal = req && !bad;
    assign hit   = lk_valid && (lk_tag == tag);
    assign wr_en = d_wr && legal && hit;

    assign d_segfault = !rst && req && bad;
    assign d_miss     = !rst && legal && !hit;
    assign d_rd_data  = (!rst && d_rd && legal && hit) ? mem[idx] : 32'h0;
    assign busy       = (state == MISS);

    miss_tag_array #(
        .LINES (LINES),
        .SET_W (SET_W),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk          (clk),
        .rst          (rst),
        .lookup_set   (set),
        .lookup_valid (lk_valid),
        .lookup_tag   (lk_tag),
        .fill_en      (fill_en),
        .fill_set     (fill_set),
        .fill_tag     (fill_tag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[idx] <= d_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            miss_trd   <= '0;
            miss_count <= '0;
            fill_set   <= '0;
            fill_tag   <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            miss_trd   <= trd_next;
            miss_count <= count_next;
            fill_set   <= fill_set_next;
            fill_tag   <= fill_tag_next;
        end
    end

    // Completion in MISS wins over any concurrent miss; that request retries from IDLE
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        trd_next      = miss_trd;
        count_next    = miss_count;
        fill_set_next = fill_set;
        fill_tag_next = fill_tag;
        fill_en       = 1'b0;
        case (state)
            IDLE: begin
                if (legal && !hit) begin
                    state_next    = MISS;
                    cnt_next      = CNT_W'(MISS_LAT - 1);
                    trd_next      = d_trd;
                    fill_set_next = set;
                    fill_tag_next = tag;
                    if (miss_count != 16'hFFFF) begin
                        count_next = miss_count + 16'd1;
                    end
                end
            end
            MISS: begin
                if (cnt == '0) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Synthesizable responder for the processor's data-memory port. Accepts the core's `d_*` requests and returns read data, a miss indication and a segfault flag. Misses are modelled with a direct-mapped tag table and a fixed-latency fill. It sits between `threadkraken_top` and on-chip word storage, and replaces behavioural memory models in FPGA and synthesis flows.

## Interface
- `DEPTH`, 1024: backing store size in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `LINE_WORDS`, 4: words per line; power of two.
- `LINES`, 16: tag-table entries; power of two.
- `MISS_LAT`, 8: cycles spent in MISS per fill; must be at least 1.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `d_addr` in 32: byte address.
- `d_wr_data` in 32: write data.
- `d_rd` in 1: read request.
- `d_wr` in 1: write request.
- `d_trd` in 3: requesting thread.
- `d_rd_data` out 32: read data; valid when `d_rd & ~d_miss & ~d_segfault`, otherwise 0.
- `d_miss` out 1: access not performed this cycle; the core must retry.
- `d_segfault` out 1: illegal access; never performed.
- `busy` out 1: a fill is in progress.
- `miss_trd` out 3: thread that started the current fill.
- `miss_count` out 16: number of fills started; saturates at 16'hFFFF.

## Operation
- Request present = `d_rd | d_wr`.
- Word index `w = (d_addr - BASE_ADDR) >> 2`.
- Line `l = w / LINE_WORDS`.
- Set `s = l % LINES`.
- Tag `t = l / LINES`.
- Segfault: asserted combinationally when a request is present and any of these hold:
  - `d_addr[1:0] != 0`
  - `d_addr < BASE_ADDR`
  - `w >= DEPTH`
  - `d_rd & d_wr`
- A segfaulting request has no side effects. `d_miss` is 0 whenever `d_segfault` is 1.
- Hit: `valid[s] && tag[s] == t`.
  - A read returns `mem[w]` combinationally.
  - A write updates `mem[w]` at the rising edge.
- Miss: a legal request that is not a hit sets `d_miss=1` and performs no access.
- FSM states:
  - IDLE: on a legal miss, load the set/tag into the fill registers, capture `d_trd` into `miss_trd`, load `cnt=MISS_LAT-1`, increment `miss_count`, and go to MISS.
  - MISS: `busy=1` and `cnt` decrements each cycle. When `cnt==0`, at the edge: `valid[fs]<=1`, `tag[fs]<=ft`, go to IDLE.
- Only one fill is outstanding at a time. During MISS:
  - Any legal request that is not a hit, from any thread, gets `d_miss=1` and starts nothing.
  - Hits from other threads are serviced normally.
- The fill completes even if the requester withdraws, switches thread or changes address.
- Write-allocate. No write-back modelling; storage is always coherent.
- A fill evicts the prior tag of its set. A line replaced mid-MISS by nothing is impossible, because only the FSM writes tags.
- Reset: all `valid` cleared, FSM to IDLE, `cnt=0`, `miss_trd=0`, `miss_count=0`, `mem` zeroed.
- Output values during reset: `d_rd_data=0`, `d_miss=0`, `d_segfault=0`, `busy=0`.
- Reset asserted mid-MISS abandons the fill; the line stays invalid.

## Timing
- Hit: zero-latency combinational response; write committed at the end of the same cycle.
- Miss first presented in cycle T:
  - `d_miss=1` in T.
  - `busy=1` in T+1 through T+MISS_LAT.
  - Line valid from T+MISS_LAT+1.
  - A retry hits at T+MISS_LAT+1 at the earliest; with defaults, T+9.
- A retry during T+1..T+MISS_LAT still gets `d_miss=1`.
- Completion edge coinciding with a new miss request: the completion takes priority. The new request sees `d_miss=1` in that cycle and is re-evaluated from IDLE the next cycle.
- `miss_count` increments at the edge ending T.

## Structure
- Package `mem_resp_pkg`:
  - `mem_resp_state_t` enum {IDLE, MISS}.
  - Derived localparam functions: index/offset/tag widths computed from DEPTH, LINE_WORDS and LINES via `$clog2`.
- Sub-module `miss_tag_array`: LINES × (valid, tag) registers, with a combinational lookup port and a single fill-write port with async clear.
- Top level holds the storage array, segfault decode, FSM and counters.

## Test plan
- Reset, then read 0x0000_0010 → `d_miss=1`; retry each cycle → `d_miss` high in cycles 0–8, hit at cycle 9 with `d_rd_data=0`, `miss_count=1`.
- Write 0xDEAD_BEEF to 0x14 after that line is filled → no miss. Read 0x14 next cycle → 0xDEAD_BEEF.
- Read 0x0000_0002 (misaligned), read DEPTH*4, and `d_rd&d_wr` at 0x0 → `d_segfault=1`, `d_miss=0`, no state or counter change.
- Thread 2 misses on 0x100; during MISS, thread 5 reads filled line 0x10 → hit. Thread 5 read of 0x200 → `d_miss=1` with no new fill. `miss_trd=2`.
- Fill 0x0, then access 0x0 + LINES*LINE_WORDS*4 → miss and eviction. Read 0x0 afterwards → miss again; data is preserved after refill.
- Assert `rst` at cycle T+4 of a fill → `busy=0` immediately, `miss_count=0`. Line still misses after release.
